// File: rtl/usb_fifo_bridge.sv
// usb_fifo_bridge
//   Bridge between the MCU peripheral bus and the USB_CDC IN/OUT byte
//   streams. The MCU writes bytes into the IN FIFO and the USB side drains
//   them. The USB side fills the OUT FIFO and the MCU pops it by reading
//   OUT_DATA. Each direction sustains one byte per cycle.
//
// Ports
//   clk_i, rstn_i       clock, asynchronous active-low reset
//   sel_i, read_i,      bus select plus one-cycle read/write strobes
//   write_i
//   addr_i, data_i      byte address and write data
//   data_o              registered read data
//   in_irq_o            pulse one cycle after each IN byte is consumed
//   out_irq_o           pulse one cycle after each OUT byte is accepted
//   irq_o               maskable level interrupt (0 unless the macro is on)
//   in_data_o,          IN FIFO head (0x00 when empty) and non-empty flag
//   in_valid_o
//   in_ready_i          USB consumes the head when high with in_valid_o
//   out_data_i,         OUT byte and valid from USB
//   out_valid_i
//   out_ready_o         OUT FIFO not full
//
// Build option
//   USB_FIFO_BRIDGE_IRQ_EN : implements the IRQ_EN register at 0x0010 and
//   drives irq_o from a flop. Without it, irq_o is 0 and 0x0010 reads 0x00.

module usb_fifo_bridge #(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        sel_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  output logic        in_irq_o,
  output logic        out_irq_o,
  output logic        irq_o,
  output logic [7:0]  in_data_o,
  output logic        in_valid_o,
  input  logic        in_ready_i,
  input  logic [7:0]  out_data_i,
  input  logic        out_valid_i,
  output logic        out_ready_o
);

  localparam int IN_PW  = $clog2(IN_DEPTH);
  localparam int IN_CW  = IN_PW + 1;
  localparam int OUT_PW = $clog2(OUT_DEPTH);
  localparam int OUT_CW = OUT_PW + 1;

  localparam logic [15:0] ADDR_IN_DATA  = 16'h0000;
  localparam logic [15:0] ADDR_STATUS   = 16'h0004;
  localparam logic [15:0] ADDR_OUT_DATA = 16'h0008;
  localparam logic [15:0] ADDR_LEVEL    = 16'h000C;
  localparam logic [15:0] ADDR_IRQ_EN   = 16'h0010;

  logic wr_stb, rd_stb;
  assign wr_stb = sel_i & write_i;
  assign rd_stb = sel_i & read_i;

  // IN FIFO (MCU -> USB)
  logic [7:0]       in_mem [IN_DEPTH];
  logic [IN_PW-1:0] in_wr_ptr, in_rd_ptr;
  logic [IN_CW-1:0] in_count, in_count_next;
  logic             in_full, in_empty, in_wr_hit, in_push, in_consume;
  logic             in_ovf;

  assign in_full    = (in_count == IN_CW'(IN_DEPTH));
  assign in_empty   = (in_count == '0);
  assign in_wr_hit  = wr_stb && (addr_i == ADDR_IN_DATA);
  // A full FIFO drops the write even if USB frees a slot this same cycle.
  assign in_push    = in_wr_hit && !in_full;
  assign in_consume = !in_empty && in_ready_i;
  assign in_valid_o = !in_empty;
  assign in_data_o  = in_empty ? 8'h00 : in_mem[in_rd_ptr];

  // OUT FIFO (USB -> MCU)
  logic [7:0]        out_mem [OUT_DEPTH];
  logic [OUT_PW-1:0] out_wr_ptr, out_rd_ptr;
  logic [OUT_CW-1:0] out_count, out_count_next;
  logic              out_full, out_empty, out_rd_hit, out_accept, out_pop;
  logic              out_udf;

  assign out_full    = (out_count == OUT_CW'(OUT_DEPTH));
  assign out_empty   = (out_count == '0);
  assign out_ready_o = !out_full;
  assign out_accept  = out_valid_i && !out_full;
  assign out_rd_hit  = rd_stb && (addr_i == ADDR_OUT_DATA);
  assign out_pop     = out_rd_hit && !out_empty;

  logic status_wr;
  assign status_wr = wr_stb && (addr_i == ADDR_STATUS);

  always_comb begin
    in_count_next = in_count;
    case ({in_push, in_consume})
      2'b10:   in_count_next = in_count + IN_CW'(1);
      2'b01:   in_count_next = in_count - IN_CW'(1);
      default: in_count_next = in_count;
    endcase
  end

  always_comb begin
    out_count_next = out_count;
    case ({out_accept, out_pop})
      2'b10:   out_count_next = out_count + OUT_CW'(1);
      2'b01:   out_count_next = out_count - OUT_CW'(1);
      default: out_count_next = out_count;
    endcase
  end

  // Storage is deliberately left out of reset; the counts gate every read.
  always_ff @(posedge clk_i) begin
    if (in_push) in_mem[in_wr_ptr] <= data_i;
    if (out_accept) out_mem[out_wr_ptr] <= out_data_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      in_wr_ptr <= '0;
      in_rd_ptr <= '0;
      in_count  <= '0;
      in_irq_o  <= 1'b0;
      in_ovf    <= 1'b0;
    end else begin
      if (in_push)    in_wr_ptr <= in_wr_ptr + IN_PW'(1);
      if (in_consume) in_rd_ptr <= in_rd_ptr + IN_PW'(1);
      in_count <= in_count_next;
      in_irq_o <= in_consume;
      // Set has priority over write-1-to-clear.
      if (in_wr_hit && in_full)       in_ovf <= 1'b1;
      else if (status_wr && data_i[4]) in_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_count  <= '0;
      out_irq_o  <= 1'b0;
      out_udf    <= 1'b0;
    end else begin
      if (out_accept) out_wr_ptr <= out_wr_ptr + OUT_PW'(1);
      if (out_pop)    out_rd_ptr <= out_rd_ptr + OUT_PW'(1);
      out_count <= out_count_next;
      out_irq_o <= out_accept;
      if (out_rd_hit && out_empty)     out_udf <= 1'b1;
      else if (status_wr && data_i[5]) out_udf <= 1'b0;
    end
  end

  logic [7:0] irq_en_rd;

`ifdef USB_FIFO_BRIDGE_IRQ_EN
  logic [1:0] irq_en, irq_en_next;
  logic       irq_q;

  assign irq_en_next = (wr_stb && (addr_i == ADDR_IRQ_EN)) ? data_i[1:0] : irq_en;

  // Evaluated on next-state values so irq_o tracks the FIFO state of the
  // same cycle while still coming straight from a flop.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      irq_en <= 2'b00;
      irq_q  <= 1'b0;
    end else begin
      irq_en <= irq_en_next;
      irq_q  <= (irq_en_next[0] && (in_count_next == '0)) ||
                (irq_en_next[1] && (out_count_next != '0));
    end
  end

  assign irq_o     = irq_q;
  assign irq_en_rd = {6'b000000, irq_en};
`else
  assign irq_o     = 1'b0;
  assign irq_en_rd = 8'h00;
`endif

  logic [7:0] status_rd, level_rd;
  assign status_rd = {2'b00, out_udf, in_ovf, out_full, out_empty, in_empty, in_full};
  assign level_rd  = {4'(out_count), 4'(in_count)};

  // Read data is captured on the strobe edge and held until the next read.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_o <= 8'h00;
    end else if (rd_stb) begin
      case (addr_i)
        ADDR_STATUS:   data_o <= status_rd;
        ADDR_OUT_DATA: data_o <= out_empty ? 8'h00 : out_mem[out_rd_ptr];
        ADDR_LEVEL:    data_o <= level_rd;
        ADDR_IRQ_EN:   data_o <= irq_en_rd;
        default:       data_o <= 8'h00;
      endcase
    end
  end

endmodule

// File: doc/usb_fifo_bridge.md
# usb_fifo_bridge

Parametrised MCU-to-USB_CDC data bridge: the second-generation FIFO interface between the MCU peripheral bus and the USB_CDC IN/OUT byte streams. It replaces the single-byte IN/OUT buffers with configurable-depth FIFOs, adds sticky overflow/underflow flags and fill-level readout, and adds an optional maskable level interrupt. It keeps the existing per-byte pulsed IRQs.

## Interface
- IN_DEPTH, 4, IN FIFO entries (MCU→USB); power of two, 2..8
- OUT_DEPTH, 4, OUT FIFO entries (USB→MCU); power of two, 2..8
- clk_i  input  1  single clock
- rstn_i  input  1  reset, asynchronous, active-low
- sel_i  input  1  bus select
- read_i  input  1  bus read strobe, one cycle
- write_i  input  1  bus write strobe, one cycle
- addr_i  input  16  byte address
- data_i  input  8  write data
- data_o  output  8  read data, registered
- in_irq_o  output  1  one-cycle pulse per IN byte consumed by USB
- out_irq_o  output  1  one-cycle pulse per OUT byte accepted from USB
- irq_o  output  1  level interrupt, see Configuration
- in_data_o  output  8  IN FIFO head
- in_valid_o  output  1  IN FIFO non-empty
- in_ready_i  input  1  USB consumes head when high with in_valid_o
- out_data_i  input  8  OUT byte from USB
- out_valid_i  input  1  out_data_i valid
- out_ready_o  output  1  OUT FIFO not full

## Operation
- Write strobe = sel_i&write_i; read strobe = sel_i&read_i. Only one strobe is active per cycle.
- Register map:
  - 0x0000 IN_DATA (W): pushes data_i into the IN FIFO. If the FIFO is full, the byte is dropped and IN_OVF is set.
  - 0x0004 STATUS (R): bit0 in_full, bit1 in_empty, bit2 out_empty, bit3 out_full, bit4 IN_OVF, bit5 OUT_UDF, others 0. Writing 1 to bit4 or bit5 clears that flag.
  - 0x0008 OUT_DATA (R): returns the OUT FIFO head and pops it. If the FIFO is empty, it returns 0x00, sets OUT_UDF and leaves the pointers unchanged.
  - 0x000C LEVEL (R): [3:0] in_count, [7:4] out_count.
  - 0x0010 IRQ_EN (R/W): bit0 in_empty enable, bit1 out_nonempty enable.
  - Other addresses read 0x00; writes to them are ignored.
- Each FIFO has a read pointer, a write pointer (log2(DEPTH) bits, natural wrap) and a count (log2(DEPTH)+1 bits). Full = count==DEPTH; empty = count==0.
- IN side:
  - in_valid_o = ~in_empty; in_data_o = mem[rd_ptr].
  - The head and valid stay stable until in_valid_o&in_ready_i.
  - On consume: rd_ptr++, count--, in_irq_o pulses the next cycle.
- OUT side:
  - out_ready_o = ~out_full.
  - On out_valid_i&out_ready_o: write, wr_ptr++, count++, out_irq_o pulses the next cycle.
- Simultaneous events:
  - IN push while full is dropped, even if a USB consume happens in the same cycle.
  - IN push and consume in the same cycle with 0<count<DEPTH: count unchanged.
  - OUT accept and MCU pop in the same cycle with count≥1: both happen, count unchanged.
  - MCU pop when full: pop proceeds; no accept that cycle because ready was low.
  - STATUS write-1-to-clear in the same cycle as a flag set: set wins.
- There are no reset-mid-operation special cases: asserting rstn_i empties both FIFOs and discards any in-flight byte.

## Timing
- Reset values: data_o=0x00, in_valid_o=0, in_data_o=0x00, out_ready_o=1, in_irq_o=0, out_irq_o=0, irq_o=0. Flags, pointers, counts and IRQ_EN are all 0.
- FIFO memory is not reset. in_data_o is forced to 0x00 while empty.
- out_ready_o is high from the first cycle after reset release.
- Read latency: data_o is loaded at the edge ending the read strobe and is valid the next cycle. It holds until the next read strobe.
- IN write at cycle N → in_valid_o=1 at N+1.
- OUT accept at cycle N → readable via 0x0008 from a read strobe at N+1.
- STATUS and LEVEL reads sample the state before that cycle's updates.
- Throughput: 1 byte/cycle each direction, sustained.

## Configuration
- USB_FIFO_BRIDGE_IRQ_EN defined:
  - IRQ_EN register is implemented.
  - irq_o = (IRQ_EN[0]&in_empty) | (IRQ_EN[1]&~out_empty), driven from flops, no glitches.
- Not defined:
  - irq_o is tied 0.
  - 0x0010 reads 0x00 and writes to it are ignored.
  - in_irq_o and out_irq_o are unaffected.

## Test plan
- Reset, then read STATUS and LEVEL → 0x06 and 0x00; out_ready_o=1, in_valid_o=0.
- Write 0x11,0x22,0x33,0x44,0x55 to 0x0000 with in_ready_i=0 (IN_DEPTH=4):
  - STATUS bit0=1, bit4=1.
  - Then in_ready_i=1 → 0x11..0x44 emitted on consecutive cycles and four in_irq_o pulses.
  - Write 0x10 to STATUS → bit4=0.
- Stream 0xA0..0xA4 on out_valid_i: out_ready_o drops after 4 accepts and there are four out_irq_o pulses. Five 0x0008 reads then return:
  - A0,A1,A2,A3 (A4 was never accepted),
  - then 0x00 with STATUS bit5=1.
- OUT count=2 with a simultaneous USB accept and MCU pop → LEVEL[7:4] stays 2 and FIFO order is preserved.
- With the macro defined, write IRQ_EN=0x02 and send one OUT byte → irq_o=1. Pop it → irq_o=0 the cycle after the pop.
- Without the macro, the same sequence → irq_o stays 0 and 0x0010 reads 0x00.
